branch_target_predictor: RTL

//  Parametrised direct-mapped branch target buffer with N-bit saturating direction

---
 rtl/branch_target_predictor_if.sv | 44 ++++
 rtl/branch_target_predictor.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/branch_target_predictor_if.sv
// Fetch/execute-side bundle for the branch target predictor.
// The pipeline drives lookups, updates and flush (master); the predictor
// answers with predictions and statistics (slave).
interface branch_target_predictor_if #(
  parameter int GHR_W = 0,
  parameter int CNT_W = 16
);
  localparam int HIST_W = (GHR_W > 0) ? GHR_W : 1;

  // fetch-side lookup and prediction
  logic [31:0]       lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [31:0]       pred_target;
  logic [HIST_W-1:0] pred_ghr;

  // execute-side training
  logic              upd_en;
  logic [31:0]       upd_pc;
  logic [HIST_W-1:0] upd_ghr;
  logic              upd_is_jump;
  logic              upd_taken;
  logic [31:0]       upd_target;
  logic              upd_mispredict;
  logic              flush;

  // statistics
  logic [CNT_W-1:0]  stat_branches;
  logic [CNT_W-1:0]  stat_mispredict;

  modport master (
    output lookup_pc, upd_en, upd_pc, upd_ghr, upd_is_jump, upd_taken,
           upd_target, upd_mispredict, flush,
    input  pred_hit, pred_taken, pred_target, pred_ghr,
           stat_branches, stat_mispredict
  );

  modport slave (
    input  lookup_pc, upd_en, upd_pc, upd_ghr, upd_is_jump, upd_taken,
           upd_target, upd_mispredict, flush,
    output pred_hit, pred_taken, pred_target, pred_ghr,
           stat_branches, stat_mispredict
  );
endinterface

// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with saturating direction counters,
// optional gshare history folding into the index, and saturating
// statistics. Lookup is combinational from registered state; training
// happens on the rising edge when the execute stage resolves a branch.
module branch_target_predictor #(
  parameter int IDX_W = 4,
  parameter int CTR_W = 2,
  parameter int GHR_W = 0,
  parameter int CNT_W = 16
) (
  input logic CLK,
  input logic RST,
  branch_target_predictor_if.slave bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX = {CTR_W{1'b1}};
  localparam logic [CTR_W-1:0] CTR_WT  = {1'b1, {(CTR_W-1){1'b0}}};
  localparam logic [CTR_W-1:0] CTR_WNT = {1'b0, {(CTR_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // per-entry state, gathered from the generate blocks for indexed reads
  logic              valid_vec  [ENTRIES];
  logic [TAG_W-1:0]  tag_arr    [ENTRIES];
  logic [31:0]       target_arr [ENTRIES];
  logic [CTR_W-1:0]  ctr_arr    [ENTRIES];
  logic              jmp_arr    [ENTRIES];

  logic [IDX_W-1:0]  ghr_lk_ext;
  logic [IDX_W-1:0]  ghr_up_ext;
  logic [IDX_W-1:0]  lidx;
  logic [IDX_W-1:0]  uidx;
  logic [TAG_W-1:0]  ltag;
  logic [TAG_W-1:0]  utag;
  logic              lk_hit;
  logic              upd_hit;
  logic [CTR_W-1:0]  ctr_cur;
  logic [CTR_W-1:0]  ctr_next;
  logic              eff_taken;
  logic              tgt_we;
  logic              tbl_we;

  logic [CNT_W-1:0]  stat_branches_reg;
  logic [CNT_W-1:0]  stat_mispredict_reg;

  // Word-offset bits never participate in indexing or tagging.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  // Lookup uses the live history; training uses the snapshot taken at
  // fetch so it lands on the same entry the lookup read.
  assign lidx = bus.lookup_pc[IDX_W+1:2] ^ ghr_lk_ext;
  assign ltag = bus.lookup_pc[31:IDX_W+2];
  assign uidx = bus.upd_pc[IDX_W+1:2] ^ ghr_up_ext;
  assign utag = bus.upd_pc[31:IDX_W+2];

  assign lk_hit  = valid_vec[lidx] && (tag_arr[lidx] == ltag);
  assign upd_hit = valid_vec[uidx] && (tag_arr[uidx] == utag);
  assign ctr_cur = ctr_arr[uidx];

  // No bypass: a same-cycle update is visible only after the edge.
  assign bus.pred_hit    = lk_hit;
  assign bus.pred_taken  = lk_hit && (jmp_arr[lidx] || ctr_arr[lidx][CTR_W-1]);
  assign bus.pred_target = lk_hit ? target_arr[lidx] : 32'h0;

  // Jumps always count as taken; a not-taken hit keeps its old target.
  assign eff_taken = bus.upd_is_jump || bus.upd_taken;
  assign tgt_we    = !upd_hit || eff_taken;
  // Flush wins over a simultaneous update for table contents.
  assign tbl_we    = bus.upd_en && !bus.flush;

  // Next direction counter value for the entry being trained.
  always_comb begin
    ctr_next = ctr_cur;
    if (bus.upd_is_jump) begin
      ctr_next = CTR_MAX;
    end else if (!upd_hit) begin
      ctr_next = bus.upd_taken ? CTR_WT : CTR_WNT;
    end else if (bus.upd_taken) begin
      if (ctr_cur != CTR_MAX) ctr_next = ctr_cur + 1'b1;
    end else begin
      if (ctr_cur != '0) ctr_next = ctr_cur - 1'b1;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
      logic              valid_reg;
      logic [CTR_W-1:0]  ctr_reg;
      logic [TAG_W-1:0]  tag_reg;
      logic [31:0]       target_reg;
      logic              jmp_reg;
      logic              sel;

      assign sel = tbl_we && (uidx == IDX_W'(gi));

      // Valid bit and counter: reset to empty/weakly-not-taken, flush clears valid only.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          valid_reg <= 1'b0;
          ctr_reg   <= CTR_WNT;
        end else if (bus.flush) begin
          valid_reg <= 1'b0;
        end else if (sel) begin
          valid_reg <= 1'b1;
          ctr_reg   <= ctr_next;
        end
      end

      // Payload fields are only meaningful while valid, so they carry no reset.
      always_ff @(posedge CLK) begin
        if (sel) begin
          tag_reg <= utag;
          jmp_reg <= bus.upd_is_jump;
          if (tgt_we) target_reg <= bus.upd_target;
        end
      end

      assign valid_vec[gi]  = valid_reg;
      assign ctr_arr[gi]    = ctr_reg;
      assign tag_arr[gi]    = tag_reg;
      assign target_arr[gi] = target_reg;
      assign jmp_arr[gi]    = jmp_reg;
    end

    if (GHR_W > 0) begin : g_ghr
      logic [GHR_W-1:0] ghr_reg;
      logic [GHR_W-1:0] ghr_next;

      if (GHR_W == 1) begin : g_one
        assign ghr_next = bus.upd_taken;
      end else begin : g_many
        assign ghr_next = {ghr_reg[GHR_W-2:0], bus.upd_taken};
      end

      // Global history shifts on conditional branches only; flush clears it.
      always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
          ghr_reg <= '0;
        end else if (bus.flush) begin
          ghr_reg <= '0;
        end else if (bus.upd_en && !bus.upd_is_jump) begin
          ghr_reg <= ghr_next;
        end
      end

      // Zero-extend both histories to index width for the XOR fold.
      always_comb begin
        ghr_lk_ext = '0;
        ghr_up_ext = '0;
        ghr_lk_ext[GHR_W-1:0] = ghr_reg;
        ghr_up_ext[GHR_W-1:0] = bus.upd_ghr;
      end

      assign bus.pred_ghr = ghr_reg;
    end else begin : g_no_ghr
      logic unused_upd_ghr;
      assign unused_upd_ghr = ^bus.upd_ghr;
      assign ghr_lk_ext     = '0;
      assign ghr_up_ext     = '0;
      assign bus.pred_ghr   = '0;
    end
  endgenerate

  // Saturating statistics; they count every resolved update, even under flush.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stat_branches_reg   <= '0;
      stat_mispredict_reg <= '0;
    end else begin
      if (bus.upd_en && (stat_branches_reg != CNT_MAX))
        stat_branches_reg <= stat_branches_reg + 1'b1;
      if (bus.upd_en && bus.upd_mispredict && (stat_mispredict_reg != CNT_MAX))
        stat_mispredict_reg <= stat_mispredict_reg + 1'b1;
    end
  end

  assign bus.stat_branches   = stat_branches_reg;
  assign bus.stat_mispredict = stat_mispredict_reg;

endmodule
